// File: rtl/uart_rx_periph.sv
// APB-slave UART receiver: 16x oversampled 8N1 deserialiser feeding an RX FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with a sticky parity-error flag.
module uart_rx_periph #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        rx,
  output logic        rx_irq
);

  localparam int unsigned DIV   = CLK_HZ / (BAUD * 16);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_e;
`endif

  logic             rx_s1_q, rx_s2_q, rxs;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  state_e           state_q, state_d;
  logic [3:0]       tcnt_q, tcnt_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_q, push_d;
  logic             ferr_set, perr_set;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic             empty_q, full_q, ovr_q, ferr_q, perr_q;
  logic             apb_acc, apb_wr, pop, push_ok, ovr_set, clr_wr;
  logic [1:0]       sel;
  logic [4:0]       status;
  logic             unused_ok;

  // Two-flop synchroniser, idles high so reset looks like a quiet line
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end
  assign rxs = rx_s2_q;

  assign tick = (div_q == DIV_W'(DIV - 1));
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) div_q <= '0;
    else        div_q <= tick ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      push_q  <= push_d;
    end
  end

  // Frame FSM: start validated at tick 7, every later bit sampled at tick 15
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    push_d   = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: if (tick) begin
        if (tcnt_q == 4'd7) begin
          tcnt_d = '0;
          bcnt_d = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      S_DATA: if (tick) begin
        tcnt_d = tcnt_q + 4'd1;
        if (tcnt_q == 4'd15) begin
          shift_d[bcnt_q] = rxs;
          bcnt_d = bcnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bcnt_q == 3'd7) state_d = S_PARITY;
`else
          if (bcnt_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (tick) begin
        tcnt_d = tcnt_q + 4'd1;
        if (tcnt_q == 4'd15) begin
          perr_set = (^shift_q) ^ rxs;
          state_d  = S_STOP;
        end
      end
`endif
      S_STOP: if (tick) begin
        tcnt_d = tcnt_q + 4'd1;
        if (tcnt_q == 4'd15) begin
          push_d   = rxs;
          ferr_set = !rxs;
          state_d  = rxs ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: if (rxs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign apb_acc = PSEL & PENABLE;
  assign apb_wr  = apb_acc & PWRITE;
  assign sel     = PADDR[3:2];
  assign pop     = apb_acc & !PWRITE & (sel == 2'd1) & !empty_q;
  assign push_ok = push_q & (!full_q | pop);
  assign ovr_set = push_q & full_q & !pop;
  assign clr_wr  = apb_wr & (sel == 2'd2);

  always_ff @(posedge PCLK) begin
    if (push_ok) mem_q[wptr_q] <= shift_q;
  end

  // Full/empty are explicit flags; equal pointers alone are ambiguous
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)     rptr_q <= rptr_q + PTR_W'(1);
      if (push_ok && !pop) begin
        empty_q <= 1'b0;
        full_q  <= ((wptr_q + PTR_W'(1)) == rptr_q);
      end else if (pop && !push_ok) begin
        full_q  <= 1'b0;
        empty_q <= ((rptr_q + PTR_W'(1)) == wptr_q);
      end
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_set  | (ovr_q  & !(clr_wr & PWDATA[2]));
      ferr_q <= ferr_set | (ferr_q & !(clr_wr & PWDATA[3]));
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) perr_q <= 1'b0;
    else        perr_q <= perr_set | (perr_q & !(clr_wr & PWDATA[4]));
  end
`else
  assign perr_q = 1'b0;
`endif

  assign status = {perr_q, ferr_q, ovr_q, full_q, empty_q};
  assign PREADY = apb_acc;
  assign rx_irq = !empty_q;

  always_comb begin
    PRDATA = '0;
    if (apb_acc) begin
      unique case (sel)
        2'd0:    PRDATA = 32'(status);
        2'd1:    if (!empty_q) PRDATA = 32'(mem_q[rptr_q]);
        default: PRDATA = '0;
      endcase
    end
  end

  assign unused_ok = ^{PWDATA, PADDR[1:0], perr_set};

endmodule

// File: doc/uart_rx_periph.md
Name: uart_rx_periph

Overview:
APB-slave UART receiver peripheral; the receive-direction counterpart to the APB UART transmit peripheral.
- Samples serial input `rx` at 16x oversampling, deserialises 8N1 frames and pushes bytes into an internal RX FIFO.
- CPU pops bytes and reads status/error flags over APB.
- Sits on the APB bus beside the other peripherals; `rx` connects to the board UART pin.

Parameters:
CLK_HZ, 100_000_000, PCLK frequency in Hz
BAUD, 9600, line baud rate; tick divisor DIV = CLK_HZ/(BAUD*16), integer, must be >= 2
FIFO_DEPTH, 4, RX FIFO entries; power of two, >= 2

Ports:
PCLK  input  1  system clock; single clock domain
PRESET  input  1  asynchronous active-high reset
PADDR  input  4  APB byte address; decode uses PADDR[3:2]
PWDATA  input  32  APB write data
PWRITE  input  1  1 = write, 0 = read
PENABLE  input  1  APB access phase
PSEL  input  1  APB slave select
PRDATA  output  32  APB read data
PREADY  output  1  APB ready
rx  input  1  asynchronous serial input; idles high
rx_irq  output  1  level interrupt: FIFO not empty

Behaviour:
- Reset values: PRDATA=0, PREADY=0, rx_irq=0. FIFO empty, pointers 0. All sticky flags 0. FSM=IDLE. Tick counter 0. Synchroniser flops preset to 1.
- rx passes through a 2-flop synchroniser. All FSM logic uses the synchronised `rxs`; 2-cycle input latency.
- Tick generator: free-running counter 0..DIV-1. One-cycle `tick` pulse when the counter wraps.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Tick counter tcnt is 4 bits; bit index bcnt is 3 bits.
  - IDLE: on rxs=0 go to START with tcnt=0.
  - START: count ticks. When tcnt reaches 7 (mid start bit):
    - rxs=1 → glitch; go to IDLE, nothing pushed.
    - rxs=0 → go to DATA with tcnt=0, bcnt=0.
  - DATA: sample rxs when tcnt reaches 15 (mid-bit). Data is LSB first into shift[bcnt]. After bcnt=7 go to STOP.
  - STOP: sample when tcnt reaches 15.
    - rxs=1 → push byte and go to IDLE.
    - rxs=0 → set FERR, discard byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE. This prevents a line break retriggering.
- Push: occurs the cycle after the stop sample.
  - FIFO full and no simultaneous pop → byte dropped, OVR set.
  - Simultaneous push and pop while full → both succeed, OVR not set.
- APB is zero-wait: PREADY = PSEL & PENABLE (combinational). PRDATA is combinational during the access phase and 0 otherwise.
- Register map, selected by PADDR[3:2]:
  - 0 STATUS (read-only): bit0 EMPTY, bit1 FULL, bit2 OVR, bit3 FERR, bit4 PERR. Other bits 0.
  - 1 RXDATA (read): PRDATA[7:0] = FIFO head; upper bits 0.
    - Read pops exactly once, in the access cycle, when not empty.
    - Read while empty returns 0 and does not pop or move pointers.
  - 2 CLEAR (write): writing 1 to bits 2/3/4 clears OVR/FERR/PERR. If a set event occurs in the same cycle, set wins.
  - 3: reads 0; writes ignored. Writes to 0 and 1 are ignored.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Full and empty are tracked explicitly, never by pointer compare alone.
- rx_irq = !EMPTY (registered flag, no extra delay).
- Reset mid-frame: immediate abort, all state returns to reset values, partial byte lost.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: frame is 8E1. After the 8 data bits, the FSM enters state PARITY and samples the parity bit at tcnt=15.
  - If data XOR parity ≠ 0, set PERR; the byte is still pushed.
  - Then go to STOP as normal.
- Undefined: 8N1, no PARITY state, STATUS bit4 always reads 0, CLEAR bit4 ignored.

Test Plan:
Bench parameters: CLK_HZ=1_600_000, BAUD=10_000 → DIV=10, 160 clocks per bit.
- Reset, then send byte 0xA5 (8N1) → rx_irq=1 within 2 cycles of frame end; STATUS=0x0; RXDATA read returns 0xA5; then STATUS=0x1 and rx_irq=0.
- Send 5 bytes 0x01..0x05 with no reads, FIFO_DEPTH=4 → STATUS=0x6 (FULL, OVR); four reads return 0x01..0x04 in order; write 0x4 to CLEAR → STATUS=0x1.
- Drive rx low for 60 clocks only (start-bit glitch) → no byte pushed, STATUS stays 0x1.
- Send 0x3C with stop bit driven 0, then hold rx low for 500 clocks → FERR=1, FIFO empty; then rx high and send 0x7E → 0x7E is received.
- Read RXDATA while empty → PRDATA=0, PREADY=1, pointers unchanged. Assert PRESET mid-DATA → next full frame 0x5A is received correctly.
- With UART_RX_PARITY_EN: send 0x03 with parity bit 1 → byte 0x03 stored and PERR=1; send 0x03 with parity bit 0 → PERR unchanged after clear.
